instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage that sits directly upstream of the RV32 R-type execute datapath and drives its `instruction` input. It holds a loadable instruction memory, a program counter and a small prefetch FIFO. It presents one instruction per cycle through a valid/ready handshake, and stops at an all-zero terminator word or at the end of memory. Loading is done through a side port while the unit is idle.

## Interface
- `IMEM_DEPTH`, default 64: instruction memory size in 32-bit words, a power of two. AW = $clog2(IMEM_DEPTH).
- `FIFO_DEPTH`, default 4: prefetch FIFO entries, a power of two, at least 2.
- `RESET_PC`, default 32'h0: start byte address, word aligned.
- `clk`, in, 1: the single clock; everything is on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `run`, in, 1: level-sensitive fetch enable.
- `load_en`, in, 1: instruction memory write strobe.
- `load_addr`, in, AW: word index to write.
- `load_data`, in, 32: word to write.
- `instruction`, out, 32: FIFO head; 32'h0 when the FIFO is empty.
- `instr_valid`, out, 1: FIFO not empty.
- `instr_ready`, in, 1: consumer accepts the head. Tie to 1 for the current datapath.
- `instr_pc`, out, 32: byte address of the head; 32'h0 when the FIFO is empty.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `done`, out, 1: high in DONE.

## Operation
- **States:** IDLE, FETCH, DRAIN, DONE.
- **IDLE:**
  - If `run`=1 and `load_en`=0, go to FETCH.
  - `load_en`=1 writes `load_data` to mem[`load_addr`] and takes priority over `run` for that cycle.
- **FETCH, issuing a read:**
  - A read is issued at mem[pc[AW+1:2]] when `run`=1 and (fifo_count + inflight) < FIFO_DEPTH.
  - On issue, pc += 4 and inflight = 1.
  - The read is synchronous, with one cycle of latency.
- **FETCH, returned words:**
  - A non-zero returned word is pushed with its PC.
  - A returned word equal to 32'h0 is the terminator. It is not pushed, and the read issued in the same cycle is discarded. pc is restored to the terminator address, and the state goes to DRAIN.
- **FETCH, end of memory:**
  - Issuing word index IMEM_DEPTH-1 means the next state is DRAIN.
  - The final word is still pushed if it is non-zero. pc never wraps.
- **FETCH, run dropped:** if `run`=0, stop issuing. When inflight=0, go to IDLE. pc and FIFO contents are kept, and fetch resumes where it stopped.
- **DRAIN:** no issue. When the FIFO is empty and inflight=0, go to DONE.
- **DONE:**
  - `done`=1.
  - `load_en` writes are allowed.
  - When `run`=0: pc = RESET_PC, go to IDLE.
- **Load port:** `load_en` is ignored in FETCH and DRAIN.
- **Consumer side:**
  - A pop occurs when `instr_valid` & `instr_ready`.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - A pop is legal in any state, including IDLE holding leftover entries.
- **Reset:**
  - State = IDLE, pc = RESET_PC.
  - FIFO emptied, inflight = 0.
  - All outputs are 0.
  - Memory contents are preserved.
  - A reset mid-fetch discards the in-flight read.

## Timing
- **Startup latency:** if `run` is sampled at edge E0 (IDLE to FETCH), the first read issues at E1 and its word is pushed at E2. So `instr_valid`=1 after E2: three edges from `run`.
- **Steady state:** with `instr_ready`=1, one instruction per cycle, with no bubbles.
- **FIFO full:** the issue stalls in the same cycle that (count + inflight) reaches FIFO_DEPTH. It resumes on the cycle after a pop.
- **Terminator to done:** `done` rises one edge after the FIFO empties and inflight=0.
- **Outputs:** all registered or directly from FIFO state. No combinational path from `instr_ready` to `instruction`.

## Test plan
- **Straight-line program:**
  - Load words 0..4 with 0x00208033, 0x40208033, 0x0020F033, 0x0020E033, 0x00000000.
  - Pulse `rst`, then hold `run`=1 and `instr_ready`=1.
  - Required: `instruction`=0x00208033 with `instr_pc`=0 first valid after the third edge, then the next three words on consecutive cycles at PC 4, 8, 12.
  - Required: the terminator word is never presented, and `done`=1.
- **Back-pressure:**
  - Same program with `instr_ready`=0.
  - Required: fifo_count stops at 4 with no further issue; pc=16 and the terminator read has not yet issued.
  - Raise `instr_ready`. Required: the same four words in order with no loss or duplication.
- **End of memory:** fill all 64 words with non-zero data, then run. Required: 64 instructions delivered, last `instr_pc`=252, then DONE with no wrap to PC 0.
- **Run drop and resume:**
  - Deassert `run` after 2 instructions are accepted.
  - Required: the state returns to IDLE with the remaining entries still poppable.
  - Reassert `run`. Required: fetch continues from the stored pc with no gap or repeat.
- **Load lockout:** assert `load_en` to word 1 during FETCH. Required: mem[1] is unchanged, as checked by a later re-run.
- **Reset mid-fetch:**
  - Assert `rst` while a read is in flight.
  - Required on the next cycle: `instr_valid`=0, fifo_count=0, `done`=0, state IDLE.
  - Rerun. Required: it restarts at RESET_PC and delivers the same first instruction.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: host control/load side plus the instruction stream to the execute stage.
interface instr_fetch_if #(
  parameter int IMEM_DEPTH = 64,
  parameter int FIFO_DEPTH = 4
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          run;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [31:0]   instruction;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_pc;
  logic [CW-1:0] fifo_count;
  logic          done;

  // master: the fetch unit, which sources the instruction stream
  modport master (
    input  run, load_en, load_addr, load_data, instr_ready,
    output instruction, instr_valid, instr_pc, fifo_count, done
  );

  // slave: host/consumer side driving control and accepting instructions
  modport slave (
    output run, load_en, load_addr, load_data, instr_ready,
    input  instruction, instr_valid, instr_pc, fifo_count, done
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: loadable IMEM, PC, sync-read issue and a prefetch FIFO that stops
// at an all-zero terminator word or the last memory word.
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_IDX = '1;
  localparam logic [CW:0]   FD       = (CW+1)'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rd_pc_q;
  logic [31:0]   rdata_q;
  logic          inflight_q;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic [31:0] mem     [IMEM_DEPTH];
  logic [31:0] fifo_w  [FIFO_DEPTH];
  logic [31:0] fifo_pc [FIFO_DEPTH];

  logic          term, push, pop, issue, mem_we;
  logic [CW:0]   occ;

  assign term   = inflight_q && (rdata_q == 32'h0);
  assign push   = inflight_q && (rdata_q != 32'h0);
  assign pop    = bus.instr_valid && bus.instr_ready;
  // Reserve a FIFO slot for the in-flight read so a returning word always fits.
  assign occ    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue  = (state_q == S_FETCH) && bus.run && !term && (occ < FD);
  assign mem_we = bus.load_en && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_IDLE: if (bus.run && !bus.load_en) state_d = S_FETCH;
      S_FETCH: begin
        if (issue) pc_d = pc_q + 32'd4;
        if (term) begin
          pc_d    = rd_pc_q;
          state_d = S_DRAIN;
        end else if (issue && (pc_q[AW+1:2] == LAST_IDX)) begin
          state_d = S_DRAIN;
        end else if (!bus.run && !inflight_q) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (term) pc_d = rd_pc_q;
        if ((count_q == '0) && !inflight_q) state_d = S_DONE;
      end
      S_DONE: if (!bus.run) begin
        pc_d    = RESET_PC;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage and read datapath carry no reset; memory survives rst by design.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[bus.load_addr] <= bus.load_data;
    if (issue) begin
      rdata_q <= mem[pc_q[AW+1:2]];
      rd_pc_q <= pc_q;
    end
    if (push) begin
      fifo_w[wptr_q]  <= rdata_q;
      fifo_pc[wptr_q] <= rd_pc_q;
    end
  end

  assign bus.instr_valid = (count_q != '0);
  assign bus.instruction = bus.instr_valid ? fifo_w[rptr_q]  : 32'h0;
  assign bus.instr_pc    = bus.instr_valid ? fifo_pc[rptr_q] : 32'h0;
  assign bus.fifo_count  = count_q;
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory-image model yields the expected instruction stream.
module tb_instr_fetch;
  localparam int DEPTH = 64;
  localparam int FD    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_if #(.IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD)) bus ();

  instr_fetch #(.IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(32'h0)) u_dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_w [$];
  logic [31:0] exp_pc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a[5:0];
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
    mem_m[a]      = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    bus.load_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected stream: words from index 0 up to the first zero or the end of memory.
  task automatic build_exp();
    exp_w.delete();
    exp_pc.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_m[i] == 32'h0) break;
      exp_w.push_back(mem_m[i]);
      exp_pc.push_back(32'(i * 4));
    end
  endtask

  task automatic check_pop(input string name);
    logic [31:0] w, p;
    checks++;
    if (exp_w.size() == 0) begin
      fails++;
      $display("FAIL %s_extra: got instr %h pc %h, required no instruction", name, bus.instruction, bus.instr_pc);
    end else begin
      w = exp_w.pop_front();
      p = exp_pc.pop_front();
      if (bus.instruction !== w || bus.instr_pc !== p) begin
        fails++;
        $display("FAIL %s: got instr %h pc %h, required instr %h pc %h", name, bus.instruction, bus.instr_pc, w, p);
      end
    end
  endtask

  task automatic consume(input string name, input int budget, input bit rnd);
    int n = 0;
    bus.run = 1'b1;
    while (n < budget && !(bus.done === 1'b1 && exp_w.size() == 0)) begin
      bus.instr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.instr_valid && bus.instr_ready) check_pop(name);
      tick();
      n++;
    end
    checks++;
    if (!(bus.done === 1'b1 && exp_w.size() == 0)) begin
      fails++;
      $display("FAIL %s_done: done=%b left=%0d, required done=1 left=0", name, bus.done, exp_w.size());
    end
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.fifo_count !== '0 || bus.done !== 1'b0 ||
        bus.instruction !== 32'h0 || bus.instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b cnt=%0d done=%b instr=%h pc=%h, required all 0",
               bus.instr_valid, bus.fifo_count, bus.done, bus.instruction, bus.instr_pc);
    end
  endtask

  task automatic test_straight();
    logic [31:0] prog [5];
    bit seen;
    prog = '{32'h00208033, 32'h40208033, 32'h0020F033, 32'h0020E033, 32'h00000000};
    for (int i = 0; i < 5; i++) load_word(i, prog[i]);
    do_reset();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL straight_latency_e1: valid=%b, required 0", bus.instr_valid);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instruction !== prog[k] || bus.instr_pc !== 32'(k * 4)) begin
        fails++;
        $display("FAIL straight_word%0d: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                 k, bus.instr_valid, bus.instruction, bus.instr_pc, prog[k], 32'(k * 4));
      end
    end
    seen = 1'b0;
    for (int n = 0; n < 20 && bus.done !== 1'b1; n++) begin
      tick();
      if (bus.instr_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL straight_term: extra_valid=%b done=%b, required extra_valid=0 done=1", seen, bus.done);
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.run = 1'b1;
    bus.instr_ready = 1'b0;
    for (int n = 0; n < 12; n++) tick();
    checks++;
    if (bus.fifo_count !== 3'(FD) || bus.done !== 1'b0 || bus.instruction !== mem_m[0]) begin
      fails++;
      $display("FAIL bp_full: cnt=%0d done=%b instr=%h, required cnt=%0d done=0 instr=%h",
               bus.fifo_count, bus.done, bus.instruction, FD, mem_m[0]);
    end
    build_exp();
    consume("bp_stream", 50, 1'b0);
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_end_of_mem();
    bit seen;
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom | 32'h1);
    build_exp();
    consume("eom_stream", 1000, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.instr_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL eom_nowrap: late_valid=%b done=%b, required late_valid=0 done=1", seen, bus.done);
    end
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_run_drop();
    int acc = 0;
    logic [2:0] c0;
    do_reset();
    for (int i = 0; i < 10; i++) load_word(i, $urandom | 32'h1);
    load_word(10, 32'h0);
    build_exp();
    bus.run = 1'b1;
    bus.instr_ready = 1'b1;
    for (int n = 0; n < 50 && acc < 2; n++) begin
      if (bus.instr_valid) begin
        check_pop("drop_pre");
        acc++;
      end
      tick();
    end
    bus.run = 1'b0;
    bus.instr_ready = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    c0 = bus.fifo_count;
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (bus.fifo_count !== c0 || c0 == 3'd0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL drop_hold: cnt=%0d earlier=%0d done=%b, required stable nonzero cnt done=0",
               bus.fifo_count, c0, bus.done);
    end
    bus.instr_ready = 1'b1;
    for (int n = 0; n < 10 && bus.instr_valid; n++) begin
      check_pop("drop_left");
      tick();
    end
    bus.instr_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL drop_idle: valid=%b done=%b, required valid=0 done=0", bus.instr_valid, bus.done);
    end
    consume("drop_resume", 200, 1'b1);
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_load_lockout();
    do_reset();
    for (int i = 0; i < 6; i++) load_word(i, $urandom | 32'h1);
    load_word(6, 32'h0);
    build_exp();
    bus.run = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    bus.load_en   = 1'b1;
    bus.load_addr = 6'd1;
    bus.load_data = 32'hDEADBEEF;
    tick();
    bus.load_en   = 1'b0;
    consume("lock_run1", 100, 1'b1);
    bus.run = 1'b0;
    tick();
    build_exp();
    consume("lock_run2", 100, 1'b0);
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    build_exp();
    bus.run = 1'b1;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    bus.run = 1'b0;
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.fifo_count !== '0 || bus.done !== 1'b0 || bus.instruction !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_clear: valid=%b cnt=%0d done=%b instr=%h, required all 0",
               bus.instr_valid, bus.fifo_count, bus.done, bus.instruction);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_idle: valid=%b, required 0", bus.instr_valid);
    end
    consume("rstmid_rerun", 100, 1'b1);
    bus.run = 1'b0;
    tick();
  endtask

  initial begin
    bus.run = 1'b0;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    test_reset();
    test_straight();
    test_backpressure();
    test_end_of_mem();
    test_run_drop();
    test_load_lockout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end
endmodule
